// File: rtl/lsu_mem_ctrl_if.sv
// Request/response handshake bundle between the execute stage and lsu_mem_ctrl.
// The master (execute stage) issues requests; the slave (controller) returns responses.
interface lsu_mem_ctrl_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic        resp_err;

   modport master (
      output req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready,
      input  req_ready, resp_valid, resp_rdata, resp_err
   );

   modport slave (
      input  req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready,
      output req_ready, resp_valid, resp_rdata, resp_err
   );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// Load/store controller for a word-organised data memory: sub-word stores by read-modify-write,
// sign/zero-extended loads. Define MISALIGN_TRAP_EN to fault misaligned half/word accesses.
module lsu_mem_ctrl #(
   parameter int unsigned MEM_DEPTH = 64,
   parameter int unsigned IDX_W     = 6
) (
   input  logic             clk,
   input  logic             reset,
   lsu_mem_ctrl_if.slave    lsu,
   output logic             MemRead,
   output logic             MemWrite,
   output logic [IDX_W-1:0] mem_index,
   output logic [31:0]      mem_wdata,
   input  logic [31:0]      mem_rdata
);

   typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

   state_t            state, state_nx;
   logic [IDX_W+1:0]  addr_q;
   logic              we_q;
   logic [2:0]        f3_q;
   logic [31:0]       word_q;
   logic [31:0]       rdata_q;
   logic              err_q;

   logic              f3_ok, range_err, mis_err, acc_err;
   logic [4:0]        lane_sh;
   logic [7:0]        byte_v;
   logic [15:0]       half_v;
   logic [31:0]       load_ext, merged;

   // Request classification, evaluated on the live request bus while IDLE.
   always_comb begin
      if (lsu.req_we)
         f3_ok = !lsu.req_funct3[2] && (lsu.req_funct3[1:0] != 2'b11);
      else
         f3_ok = (lsu.req_funct3[1:0] != 2'b11) && !(lsu.req_funct3[2] && lsu.req_funct3[1]);
      range_err = (lsu.req_addr[31:2] >= 30'(MEM_DEPTH));
`ifdef MISALIGN_TRAP_EN
      mis_err = ((lsu.req_funct3[1:0] == 2'b01) && lsu.req_addr[0]) ||
                ((lsu.req_funct3[1:0] == 2'b10) && (lsu.req_addr[1:0] != 2'b00));
`else
      mis_err = 1'b0;
`endif
      acc_err = !f3_ok || range_err || mis_err;
   end

   // Lane select for load extraction and sub-word merge.
   always_comb begin
      lane_sh  = {addr_q[1:0], 3'b000};
      byte_v   = 8'(mem_rdata >> lane_sh);
      half_v   = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      load_ext = mem_rdata;
      merged   = word_q;
      case (f3_q[1:0])
         2'b00: begin
            load_ext = f3_q[2] ? {24'h0, byte_v} : {{24{byte_v[7]}}, byte_v};
            merged   = (mem_rdata & ~(32'hFF << lane_sh)) | ({24'h0, word_q[7:0]} << lane_sh);
         end
         2'b01: begin
            load_ext = f3_q[2] ? {16'h0, half_v} : {{16{half_v[15]}}, half_v};
            merged   = addr_q[1] ? {word_q[15:0], mem_rdata[15:0]} : {mem_rdata[31:16], word_q[15:0]};
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: if (lsu.req_valid) begin
            if (acc_err)
               state_nx = RESP;
            else if (lsu.req_we && (lsu.req_funct3[1:0] == 2'b10))
               state_nx = WRITE;
            else
               state_nx = READ;
         end
         READ:    state_nx = we_q ? WRITE : RESP;
         WRITE:   state_nx = RESP;
         RESP:    if (lsu.resp_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // word_q holds store data from acceptance and becomes the merged word after READ.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         addr_q  <= '0;
         we_q    <= 1'b0;
         f3_q    <= '0;
         word_q  <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         case (state)
            IDLE: if (lsu.req_valid) begin
               addr_q  <= lsu.req_addr[IDX_W+1:0];
               we_q    <= lsu.req_we;
               f3_q    <= lsu.req_funct3;
               word_q  <= lsu.req_wdata;
               rdata_q <= '0;
               err_q   <= acc_err;
            end
            READ: begin
               if (we_q) word_q  <= merged;
               else      rdata_q <= load_ext;
            end
            default: ;
         endcase
      end
   end

   assign lsu.req_ready  = (state == IDLE);
   assign lsu.resp_valid = (state == RESP);
   assign lsu.resp_rdata = rdata_q;
   assign lsu.resp_err   = err_q;
   assign MemRead        = (state == READ);
   assign MemWrite       = (state == WRITE);
   assign mem_index      = addr_q[IDX_W+1:2];
   assign mem_wdata      = (state == WRITE) ? word_q : '0;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Randomized self-checking bench for lsu_mem_ctrl against a word-array reference model.
// Compile with +define+MISALIGN_TRAP_EN on both files to exercise the trap build.
module tb_lsu_mem_ctrl;
   localparam int unsigned DEPTH = 64;

   logic        clk;
   logic        reset;
   logic        MemRead, MemWrite;
   logic [5:0]  mem_index;
   logic [31:0] mem_wdata, mem_rdata;
   logic [31:0] mem     [DEPTH];
   logic [31:0] ref_mem [DEPTH];
   int unsigned n_pass, n_total;

   lsu_mem_ctrl_if bus ();

   lsu_mem_ctrl #(.MEM_DEPTH(DEPTH), .IDX_W(6)) dut (
      .clk       (clk),
      .reset     (reset),
      .lsu       (bus),
      .MemRead   (MemRead),
      .MemWrite  (MemWrite),
      .mem_index (mem_index),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Data_memory stand-in: combinational read, clocked whole-word write.
   assign mem_rdata = mem[mem_index];
   always @(posedge clk) if (MemWrite) mem[mem_index] <= mem_wdata;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic check_reset_vals();
      check_eq("rst_req_ready", bus.req_ready, 1);
      check_eq("rst_resp_valid", bus.resp_valid, 0);
      check_eq("rst_resp_rdata", bus.resp_rdata, 0);
      check_eq("rst_resp_err", bus.resp_err, 0);
      check_eq("rst_memread", MemRead, 0);
      check_eq("rst_memwrite", MemWrite, 0);
      check_eq("rst_mem_index", 32'(mem_index), 0);
      check_eq("rst_mem_wdata", mem_wdata, 0);
   endtask

   // Reference: outcome of one access, with ref_mem updated for stores.
   task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic err, output logic [31:0] rd,
                        output int unsigned lat, output int unsigned nrd, output int unsigned nwr);
      logic        legal, mis;
      logic [31:0] word, b, h;
      int unsigned idx, off, sz, sh;
      legal = we ? (f3 <= 3'd2) : (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
      off = addr % 4;
      idx = (addr / 4) % DEPTH;
      sz  = f3 % 4;
      sh  = (off >= 2) ? 16 : 0;
      mis = 1'b0;
`ifdef MISALIGN_TRAP_EN
      mis = (sz == 1 && off % 2 != 0) || (sz == 2 && off != 0);
`endif
      err = !legal || (addr >= DEPTH * 4) || mis;
      rd = 0; nrd = 0; nwr = 0; lat = 1;
      if (!err) begin
         word = ref_mem[idx];
         b = (word >> (8 * off)) % 256;
         h = (word >> sh) % 65536;
         if (!we) begin
            lat = 2; nrd = 1;
            case (f3)
               3'd0: rd = (b >= 128) ? b + 32'hFFFFFF00 : b;
               3'd4: rd = b;
               3'd1: rd = (h >= 32768) ? h + 32'hFFFF0000 : h;
               3'd5: rd = h;
               default: rd = word;
            endcase
         end else begin
            nwr = 1;
            if (sz == 2) begin
               lat = 2;
               ref_mem[idx] = wdata;
            end else begin
               lat = 3; nrd = 1;
               if (sz == 0) ref_mem[idx] = word - (b << (8 * off)) + ((wdata % 256) << (8 * off));
               else         ref_mem[idx] = word - (h << sh) + ((wdata % 65536) << sh);
            end
         end
      end
   endtask

   task automatic do_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input int unsigned hold,
                         output logic [31:0] rd_o, output logic err_o);
      logic        e_err, seen;
      logic [31:0] e_rd;
      int unsigned e_lat, e_nrd, e_nwr, lat, nrd, nwr, both;
      model(we, f3, addr, wdata, e_err, e_rd, e_lat, e_nrd, e_nwr);
      @(negedge clk);
      check_eq("req_ready_idle", bus.req_ready, 1);
      bus.req_we = we; bus.req_funct3 = f3; bus.req_addr = addr; bus.req_wdata = wdata;
      bus.req_valid = 1'b1;
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      lat = 0; nrd = 0; nwr = 0; both = 0; seen = 1'b0;
      while (!seen && lat < 8) begin
         @(negedge clk);
         lat++;
         if (MemRead) nrd++;
         if (MemWrite) nwr++;
         if (MemRead && MemWrite) both++;
         if (MemRead || MemWrite) check_eq("mem_index", 32'(mem_index), (addr >> 2) % DEPTH);
         seen = bus.resp_valid;
      end
      check_eq("resp_valid", bus.resp_valid, 1);
      check_eq("latency", lat, e_lat);
      check_eq("resp_err", bus.resp_err, e_err);
      check_eq("resp_rdata", bus.resp_rdata, e_rd);
      check_eq("memread_cycles", nrd, e_nrd);
      check_eq("memwrite_cycles", nwr, e_nwr);
      check_eq("rd_wr_overlap", both, 0);
      rd_o = bus.resp_rdata;
      err_o = bus.resp_err;
      for (int unsigned i = 0; i < hold; i++) begin
         bus.req_valid = 1'b1; bus.req_we = 1'($urandom); bus.req_funct3 = 3'($urandom);
         bus.req_addr = $urandom_range(0, 255); bus.req_wdata = $urandom;
         @(negedge clk);
         check_eq("hold_valid", bus.resp_valid, 1);
         check_eq("hold_rdata", bus.resp_rdata, e_rd);
         check_eq("hold_err", bus.resp_err, e_err);
         check_eq("hold_req_ready", bus.req_ready, 0);
         check_eq("hold_mem_idle", {MemRead, MemWrite}, 0);
      end
      bus.resp_ready = 1'b1;
      @(posedge clk);
      #1 bus.resp_ready = 1'b0;
      bus.req_valid = 1'b0;
      check_eq("resp_dropped", bus.resp_valid, 0);
   endtask

   logic [31:0] r;
   logic        e;
   logic [31:0] a;

   initial begin
      n_pass = 0; n_total = 0;
      for (int i = 0; i < DEPTH; i++) begin mem[i] = '0; ref_mem[i] = '0; end
      bus.req_valid = 0; bus.req_we = 0; bus.req_funct3 = 0; bus.req_addr = 0;
      bus.req_wdata = 0; bus.resp_ready = 0;
      reset = 1'b0;
      #1 check_reset_vals();
      repeat (2) @(negedge clk);
      reset = 1'b1;

      do_txn(1, 3'd2, 32'h10, 32'hDEADBEEF, 0, r, e);
      do_txn(0, 3'd2, 32'h10, 32'h0, 0, r, e);
      check_eq("tp_lw", r, 32'hDEADBEEF);
      do_txn(1, 3'd0, 32'h11, 32'h55, 1, r, e);
      do_txn(0, 3'd2, 32'h10, 32'h0, 0, r, e);
      check_eq("tp_sb_merge", r, 32'hDEAD55EF);
      do_txn(1, 3'd2, 32'h10, 32'h80FF7F01, 0, r, e);
      do_txn(0, 3'd0, 32'h13, 32'h0, 0, r, e);
      check_eq("tp_lb", r, 32'hFFFFFF80);
      do_txn(0, 3'd4, 32'h13, 32'h0, 0, r, e);
      check_eq("tp_lbu", r, 32'h00000080);
      do_txn(0, 3'd1, 32'h12, 32'h0, 0, r, e);
      check_eq("tp_lh", r, 32'hFFFF80FF);
      do_txn(0, 3'd5, 32'h10, 32'h0, 0, r, e);
      check_eq("tp_lhu", r, 32'h00007F01);
      do_txn(0, 3'd2, 32'h100, 32'h0, 0, r, e);
      check_eq("tp_oor_err", e, 1);
      check_eq("tp_oor_rdata", r, 0);
      do_txn(0, 3'd2, 32'h12, 32'h0, 0, r, e);
`ifdef MISALIGN_TRAP_EN
      check_eq("tp_mis_err", e, 1);
`else
      check_eq("tp_mis_rdata", r, 32'h80FF7F01);
`endif
      do_txn(0, 3'd2, 32'h10, 32'h0, 5, r, e);

      // Reset asserted during the WRITE cycle of an SB must abandon the write.
      @(negedge clk);
      bus.req_we = 1; bus.req_funct3 = 3'd0; bus.req_addr = 32'h21; bus.req_wdata = 32'hA5;
      bus.req_valid = 1'b1;
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      @(negedge clk);
      check_eq("rst_tc_read", MemRead, 1);
      @(negedge clk);
      check_eq("rst_tc_write", MemWrite, 1);
      #2 reset = 1'b0;
      #1 check_reset_vals();
      @(negedge clk);
      reset = 1'b1;
      #1 check_eq("rst_tc_ready", bus.req_ready, 1);
      check_eq("rst_tc_mem", mem[8], ref_mem[8]);

      for (int unsigned n = 0; n < 200; n++) begin
         a = $urandom_range(0, 255);
         if ($urandom_range(0, 7) == 0) a = a | (32'h100 << $urandom_range(0, 23));
         do_txn(1'($urandom), 3'($urandom), a, $urandom, $urandom_range(0, 3), r, e);
      end

      for (int i = 0; i < DEPTH; i++) check_eq("final_mem", mem[i], ref_mem[i]);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
